// File: rtl/ysyx_23060059_hazard_ctrl.sv
// ysyx_23060059_hazard_ctrl
//   Issue scheduler between IDU and EXU. Counts pending GPR/CSR writers from
//   issue until WBU retire, and holds off issue on RAW hazards, CSR WAW, a full
//   in-flight window, or around serialising instructions. No forwarding.
//
// Ports
//   clock, reset                : clock, synchronous active-high reset
//   issue_valid / issue_ready   : IDU->EXU handshake, fire = valid & ready
//   issue_rs1/rs2(_en)          : GPR source operands
//   issue_rd, issue_reg_en      : GPR destination
//   issue_csr, issue_csr_ren,
//   issue_csreg_en              : CSR read / write
//   issue_serial                : ecall/ebreak/csr-write serialisation request
//   wb_valid, wb_rd, wb_reg_en,
//   wb_csr_rd, wb_csreg_en      : retire of one instruction
//   gpr_busy_o, csr_busy_o      : per-register pending-write flags
//   inflight_o                  : issued but not yet retired
//   err_o                       : sticky counter underflow flag
module ysyx_23060059_hazard_ctrl #(
   parameter int unsigned MAX_INFLIGHT = 3,
   parameter int unsigned CNT_W        = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [4:0]       issue_rs1,
   input  logic             issue_rs1_en,
   input  logic [4:0]       issue_rs2,
   input  logic             issue_rs2_en,
   input  logic [4:0]       issue_rd,
   input  logic             issue_reg_en,
   input  logic [1:0]       issue_csr,
   input  logic             issue_csr_ren,
   input  logic             issue_csreg_en,
   input  logic             issue_serial,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_en,
   input  logic [1:0]       wb_csr_rd,
   input  logic             wb_csreg_en,
   output logic [31:0]      gpr_busy_o,
   output logic [3:0]       csr_busy_o,
   output logic [CNT_W-1:0] inflight_o,
   output logic             err_o
);

   typedef enum logic [0:0] {StRun, StSerial} state_e;

   state_e           r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt  [32];
   logic [CNT_W-1:0] r_ccnt [4];
   logic [CNT_W-1:0] r_inflight;
   logic             r_err;

   logic [CNT_W-1:0] w_cnt_d  [32];
   logic [CNT_W-1:0] w_ccnt_d [4];
   logic [CNT_W-1:0] w_inflight_d;
   logic             w_err_d;
   logic [CNT_W:0]   w_upd;

   logic w_hazard;
   logic w_ready_run;
   logic w_fire;

   // Returns {underflow, next_count}. Simultaneous inc and dec cancel out;
   // increments saturate, decrements at zero stay at zero and flag underflow.
   function automatic logic [CNT_W:0] f_upd(input logic [CNT_W-1:0] c,
                                           input logic inc, input logic dec);
      logic [CNT_W:0] res;
      res = {1'b0, c};
      if (inc && !dec) begin
         if (c != '1) res[CNT_W-1:0] = c + CNT_W'(1);
      end else if (dec && !inc) begin
         if (c == '0) res[CNT_W] = 1'b1;
         else         res[CNT_W-1:0] = c - CNT_W'(1);
      end
      return res;
   endfunction

   // Readiness looks only at registered counters, never at wb_*, so a retire
   // releases a dependent instruction one cycle later.
   always_comb begin
      w_hazard = 1'b0;
      if (issue_rs1_en && (issue_rs1 != 5'd0) && (r_cnt[issue_rs1] != '0)) w_hazard = 1'b1;
      if (issue_rs2_en && (issue_rs2 != 5'd0) && (r_cnt[issue_rs2] != '0)) w_hazard = 1'b1;
      // CSR read-after-write and write-after-write both wait for the older writer
      if ((issue_csr_ren || issue_csreg_en) && (r_ccnt[issue_csr] != '0)) w_hazard = 1'b1;

      w_ready_run = !w_hazard && (r_inflight < CNT_W'(MAX_INFLIGHT)) &&
                    (!issue_serial || (r_inflight == '0));
      issue_ready = (r_state == StRun) && w_ready_run;
      w_fire      = issue_valid && issue_ready;
   end

   always_comb begin
      w_err_d  = r_err;
      w_upd    = '0;
      w_cnt_d  = r_cnt;
      w_ccnt_d = r_ccnt;

      // x0 is never tracked
      for (int i = 1; i < 32; i++) begin
         w_upd = f_upd(r_cnt[i],
                       w_fire && issue_reg_en && (issue_rd == 5'(i)),
                       wb_valid && wb_reg_en && (wb_rd == 5'(i)));
         w_cnt_d[i] = w_upd[CNT_W-1:0];
         if (w_upd[CNT_W]) w_err_d = 1'b1;
      end

      for (int j = 0; j < 4; j++) begin
         w_upd = f_upd(r_ccnt[j],
                       w_fire && issue_csreg_en && (issue_csr == 2'(j)),
                       wb_valid && wb_csreg_en && (wb_csr_rd == 2'(j)));
         w_ccnt_d[j] = w_upd[CNT_W-1:0];
         if (w_upd[CNT_W]) w_err_d = 1'b1;
      end

      w_upd        = f_upd(r_inflight, w_fire, wb_valid);
      w_inflight_d = w_upd[CNT_W-1:0];
      if (w_upd[CNT_W]) w_err_d = 1'b1;
   end

   // Leaving SERIAL on the edge where the last instruction retires lets the
   // next instruction issue in the following cycle.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StRun:    if (w_fire && issue_serial) w_state_d = StSerial;
         StSerial: if (w_inflight_d == '0)     w_state_d = StRun;
         default:  w_state_d = StRun;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= StRun;
         r_inflight <= '0;
         r_err      <= 1'b0;
         for (int i = 0; i < 32; i++) r_cnt[i]  <= '0;
         for (int j = 0; j < 4; j++)  r_ccnt[j] <= '0;
      end else begin
         r_state    <= w_state_d;
         r_inflight <= w_inflight_d;
         r_err      <= w_err_d;
         r_cnt      <= w_cnt_d;
         r_ccnt     <= w_ccnt_d;
      end
   end

   always_comb begin
      gpr_busy_o = '0;
      for (int i = 1; i < 32; i++) gpr_busy_o[i] = (r_cnt[i] != '0);
      csr_busy_o = '0;
      for (int j = 0; j < 4; j++) csr_busy_o[j] = (r_ccnt[j] != '0);
   end

   assign inflight_o = r_inflight;
   assign err_o      = r_err;

endmodule

// File: tb/tb_ysyx_23060059_hazard_ctrl.sv
// Testbench for ysyx_23060059_hazard_ctrl: scenario tasks push expected values
// into a queue when stimulus is driven and pop them when the DUT is sampled.
module tb_ysyx_23060059_hazard_ctrl;

   logic        clock, reset;
   logic        issue_valid, issue_ready;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_rs1_en, issue_rs2_en, issue_reg_en;
   logic [1:0]  issue_csr;
   logic        issue_csr_ren, issue_csreg_en, issue_serial;
   logic        wb_valid, wb_reg_en, wb_csreg_en;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_csr_rd;
   logic [31:0] gpr_busy_o;
   logic [3:0]  csr_busy_o;
   logic [1:0]  inflight_o;
   logic        err_o;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] e;

   ysyx_23060059_hazard_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_rs1      (issue_rs1),
      .issue_rs1_en   (issue_rs1_en),
      .issue_rs2      (issue_rs2),
      .issue_rs2_en   (issue_rs2_en),
      .issue_rd       (issue_rd),
      .issue_reg_en   (issue_reg_en),
      .issue_csr      (issue_csr),
      .issue_csr_ren  (issue_csr_ren),
      .issue_csreg_en (issue_csreg_en),
      .issue_serial   (issue_serial),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_reg_en      (wb_reg_en),
      .wb_csr_rd      (wb_csr_rd),
      .wb_csreg_en    (wb_csreg_en),
      .gpr_busy_o     (gpr_busy_o),
      .csr_busy_o     (csr_busy_o),
      .inflight_o     (inflight_o),
      .err_o          (err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_issue(input logic v, input logic [4:0] rs1, input logic rs1_en,
                            input logic [4:0] rs2, input logic rs2_en,
                            input logic [4:0] rd, input logic reg_en,
                            input logic [1:0] csr, input logic csr_ren,
                            input logic csreg_en, input logic serial);
      issue_valid    = v;
      issue_rs1      = rs1;
      issue_rs1_en   = rs1_en;
      issue_rs2      = rs2;
      issue_rs2_en   = rs2_en;
      issue_rd       = rd;
      issue_reg_en   = reg_en;
      issue_csr      = csr;
      issue_csr_ren  = csr_ren;
      issue_csreg_en = csreg_en;
      issue_serial   = serial;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] rd, input logic reg_en,
                         input logic [1:0] csr, input logic csreg_en);
      wb_valid    = v;
      wb_rd       = rd;
      wb_reg_en   = reg_en;
      wb_csr_rd   = csr;
      wb_csreg_en = csreg_en;
   endtask

   task automatic idle();
      set_issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL reset_ready got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL reset_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (gpr_busy_o !== e) begin bad++; $display("FAIL reset_gpr_busy got=%h exp=%h", gpr_busy_o, e); end
      e = exp_q.pop_front(); total++;
      if (csr_busy_o !== e[3:0]) begin bad++; $display("FAIL reset_csr_busy got=%h exp=%h", csr_busy_o, e[3:0]); end
      e = exp_q.pop_front(); total++;
      if (err_o !== e[0]) begin bad++; $display("FAIL reset_err got=%0b exp=%0b", err_o, e[0]); end
   endtask

   task automatic test_issue_basic();
      do_reset();
      set_issue(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL basic_ready got=%0b exp=%0b", issue_ready, e[0]); end
      tick(); idle();
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL basic_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
      set_wb(1, 0, 0, 0, 0);
      tick(); idle();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL basic_retire got=%0d exp=%0d", inflight_o, e[1:0]); end
   endtask

   task automatic test_raw();
      do_reset();
      set_issue(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      tick();
      set_issue(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL raw_stall got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (gpr_busy_o[5] !== e[0]) begin bad++; $display("FAIL raw_busy5 got=%0b exp=%0b", gpr_busy_o[5], e[0]); end
      tick();
      set_wb(1, 5, 1, 0, 0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL raw_same_cycle got=%0b exp=%0b", issue_ready, e[0]); end
      tick();
      set_wb(0, 0, 0, 0, 0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL raw_release got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (gpr_busy_o[5] !== e[0]) begin bad++; $display("FAIL raw_busy5_clr got=%0b exp=%0b", gpr_busy_o[5], e[0]); end
      tick(); idle();
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL raw_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
   endtask

   task automatic test_x0();
      do_reset();
      set_issue(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tick();
      set_issue(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL x0_ready got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (gpr_busy_o !== e) begin bad++; $display("FAIL x0_busy got=%h exp=%h", gpr_busy_o, e); end
      tick(); idle();
      exp_q.push_back(32'd2);
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL x0_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         set_issue(1, 0, 0, 0, 0, 5'(k), 1, 0, 0, 0, 0);
         exp_q.push_back(32'd1);
         #1;
         e = exp_q.pop_front(); total++;
         if (issue_ready !== e[0]) begin bad++; $display("FAIL b2b_ready%0d got=%0b exp=%0b", k, issue_ready, e[0]); end
         tick();
      end
      set_issue(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
      set_wb(1, 1, 1, 0, 0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd3);
      exp_q.push_back(32'h0000_000E);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL full_stall got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL full_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (gpr_busy_o !== e) begin bad++; $display("FAIL full_busy got=%h exp=%h", gpr_busy_o, e); end
      tick();
      // rd=4 issues while rd=2 retires
      set_wb(1, 2, 1, 0, 0);
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL b2b_refill got=%0b exp=%0b", issue_ready, e[0]); end
      tick();
      // WAW on rd=3 issuing alongside the retire of the older rd=3 writer
      set_issue(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      set_wb(1, 3, 1, 0, 0);
      exp_q.push_back(32'd2);
      exp_q.push_back(32'h0000_0018);
      #1;
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL b2b_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (gpr_busy_o !== e) begin bad++; $display("FAIL b2b_busy got=%h exp=%h", gpr_busy_o, e); end
      tick(); idle();
      exp_q.push_back(32'd2);
      exp_q.push_back(32'h0000_0018);
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL net0_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (gpr_busy_o !== e) begin bad++; $display("FAIL net0_busy got=%h exp=%h", gpr_busy_o, e); end
   endtask

   task automatic test_serial();
      do_reset();
      set_issue(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      tick();
      set_issue(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
      tick();
      set_issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL serial_wait2 got=%0b exp=%0b", issue_ready, e[0]); end
      tick();
      set_wb(1, 1, 1, 0, 0);
      tick();
      set_wb(1, 2, 1, 0, 0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL serial_wait1 got=%0b exp=%0b", issue_ready, e[0]); end
      tick();
      set_wb(0, 0, 0, 0, 0);
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL serial_go got=%0b exp=%0b", issue_ready, e[0]); end
      tick();
      set_issue(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL serial_block got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL serial_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
      set_wb(1, 0, 0, 0, 0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL serial_retire_cyc got=%0b exp=%0b", issue_ready, e[0]); end
      tick();
      set_wb(0, 0, 0, 0, 0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL serial_exit got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL serial_drain got=%0d exp=%0d", inflight_o, e[1:0]); end
      idle();
   endtask

   task automatic test_csr();
      do_reset();
      set_issue(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      tick();
      // second writer of the same CSR must wait
      set_issue(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'h2);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL csr_waw got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (csr_busy_o !== e[3:0]) begin bad++; $display("FAIL csr_busy got=%h exp=%h", csr_busy_o, e[3:0]); end
      set_issue(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL csr_raw got=%0b exp=%0b", issue_ready, e[0]); end
      set_issue(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL csr_other got=%0b exp=%0b", issue_ready, e[0]); end
      set_issue(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      set_wb(1, 0, 0, 1, 1);
      tick();
      set_wb(0, 0, 0, 0, 0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); total++;
      if (issue_ready !== e[0]) begin bad++; $display("FAIL csr_release got=%0b exp=%0b", issue_ready, e[0]); end
      e = exp_q.pop_front(); total++;
      if (csr_busy_o !== e[3:0]) begin bad++; $display("FAIL csr_busy_clr got=%h exp=%h", csr_busy_o, e[3:0]); end
      idle();
      // nothing in flight: a retire underflows
      set_wb(1, 0, 0, 0, 0);
      tick();
      set_wb(0, 0, 0, 0, 0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); total++;
      if (err_o !== e[0]) begin bad++; $display("FAIL err_set got=%0b exp=%0b", err_o, e[0]); end
      e = exp_q.pop_front(); total++;
      if (inflight_o !== e[1:0]) begin bad++; $display("FAIL err_inflight got=%0d exp=%0d", inflight_o, e[1:0]); end
      tick();
      tick();
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); total++;
      if (err_o !== e[0]) begin bad++; $display("FAIL err_sticky got=%0b exp=%0b", err_o, e[0]); end
      do_reset();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); total++;
      if (err_o !== e[0]) begin bad++; $display("FAIL err_clear got=%0b exp=%0b", err_o, e[0]); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_issue_basic();
      test_raw();
      test_x0();
      test_back_to_back();
      test_serial();
      test_csr();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
